// File: rtl/ser_rcv_buf.sv
// Buffered 8N1 serial receiver: synchronizes rxd, deserializes LSB-first frames
// at a programmable bit length and queues bytes in a small FIFO with error flags.
module ser_rcv_buf #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] bit_len,
    input  logic        done,
    input  logic        err_clr,
    output logic        rdy,
    output logic [7:0]  data,
    output logic        ovr,
    output logic        frm_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic                  rxd_m;
    logic                  rxd_s;
    logic [2:0]            state;
    logic [15:0]           cnt;
    logic [15:0]           len_q;
    logic [15:0]           len_eff;
    logic [2:0]            idx;
    logic [7:0]            shreg;
    logic                  push_req;
    logic                  frm_set;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  pop;
    logic                  do_push;
    logic                  ovr_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign len_eff  = (bit_len < 16'd4) ? 16'd4 : bit_len;
    assign push_req = (state == STOP) && (cnt == 16'd0) && rxd_s;
    assign frm_set  = (state == STOP) && (cnt == 16'd0) && !rxd_s;

    // Start sample lands mid-bit by loading half a bit; later samples are one bit apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
            len_q <= 16'd4;
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        cnt   <= (len_eff >> 1) - 16'd1;
                        len_q <= len_eff;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (!rxd_s) begin
                        cnt   <= len_q - 16'd1;
                        idx   <= 3'd0;
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shreg <= {rxd_s, shreg[7:1]};
                        cnt   <= len_q - 16'd1;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rxd_s) begin
                        state <= IDLE;
                    end else begin
                        state <= BRK;
                    end
                end
                BRK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full    = (count == FULL_CNT);
    assign rdy     = (count != '0);
    assign pop     = done && rdy;
    assign do_push = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;
    assign data    = rdy ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (err_clr) begin
                ovr <= 1'b0;
            end
            if (frm_set) begin
                frm_err <= 1'b1;
            end else if (err_clr) begin
                frm_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ser_rcv_buf.sv
// Scoreboard bench for ser_rcv_buf: directed frames push expected bytes, a monitor
// checks every popped byte against the queue in order.
module tb_ser_rcv_buf;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [15:0] bit_len;
    logic        done;
    logic        err_clr;
    logic        rdy;
    logic [7:0]  data;
    logic        ovr;
    logic        frm_err;

    int          checks;
    int          failures;
    logic [7:0]  exp_q [$];

    ser_rcv_buf #(.DEPTH_LOG2(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .bit_len (bit_len),
        .done    (done),
        .err_clr (err_clr),
        .rdy     (rdy),
        .data    (data),
        .ovr     (ovr),
        .frm_err (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drives one full frame; caller is positioned just after a rising edge.
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input int len);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rxd = frame[j];
            repeat (len) @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_n(input int n);
        @(posedge clk);
        #1 done = 1'b1;
        repeat (n) @(posedge clk);
        #1 done = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    // Every accepted pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (rst && done && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pop actual=0x%0h expected=none", data);
            end else begin
                check_output("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        rxd      = 1'b1;
        done     = 1'b0;
        err_clr  = 1'b0;
        bit_len  = 16'd434;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_rdy", {31'd0, rdy}, 32'd0);
        check_output("reset_data", {24'd0, data}, 32'd0);
        check_output("reset_ovr", {31'd0, ovr}, 32'd0);
        check_output("reset_frm", {31'd0, frm_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] single byte 0x55 at bit_len 434");
        @(posedge clk);
        #1;
        exp_q.push_back(8'h55);
        fork
            apply_stimulus(8'h55, 1'b1, 434);
            begin
                repeat (4125) @(posedge clk);
                @(negedge clk);
                check_output("t1_rdy_before", {31'd0, rdy}, 32'd0);
                @(negedge clk);
                check_output("t1_rdy_at", {31'd0, rdy}, 32'd1);
                check_output("t1_data", {24'd0, data}, 32'h55);
            end
        join
        pop_n(1);
        @(negedge clk);
        check_output("t1_rdy_after_pop", {31'd0, rdy}, 32'd0);
        check_output("t1_data_after_pop", {24'd0, data}, 32'd0);
        pop_n(2);
        @(negedge clk);
        check_output("t1_empty_done_rdy", {31'd0, rdy}, 32'd0);

        $display("[TB] glitch rejection");
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (100) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        check_output("t2_rdy", {31'd0, rdy}, 32'd0);
        check_output("t2_ovr", {31'd0, ovr}, 32'd0);
        check_output("t2_frm", {31'd0, frm_err}, 32'd0);

        $display("[TB] overrun and order");
        bit_len = 16'd16;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            apply_stimulus(8'(i), 1'b1, 16);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_output("t3_ovr", {31'd0, ovr}, 32'd1);
        check_output("t3_rdy", {31'd0, rdy}, 32'd1);
        check_output("t3_head", {24'd0, data}, 32'h00);
        pop_n(16);
        @(negedge clk);
        check_output("t3_rdy_drained", {31'd0, rdy}, 32'd0);
        check_output("t3_queue_left", exp_q.size(), 32'd0);
        pulse_err_clr();
        @(negedge clk);
        check_output("t3_ovr_cleared", {31'd0, ovr}, 32'd0);

        $display("[TB] framing error and break");
        @(posedge clk);
        #1;
        apply_stimulus(8'hA3, 1'b0, 16);
        repeat (5000) @(posedge clk);
        @(negedge clk);
        check_output("t4_frm", {31'd0, frm_err}, 32'd1);
        check_output("t4_rdy_break", {31'd0, rdy}, 32'd0);
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        exp_q.push_back(8'h3C);
        apply_stimulus(8'h3C, 1'b1, 16);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("t4_rdy_after", {31'd0, rdy}, 32'd1);
        check_output("t4_frm_sticky", {31'd0, frm_err}, 32'd1);
        pop_n(1);
        @(negedge clk);
        check_output("t4_queue_left", exp_q.size(), 32'd0);
        check_output("t4_rdy_drained", {31'd0, rdy}, 32'd0);
        pulse_err_clr();
        @(negedge clk);
        check_output("t4_frm_cleared", {31'd0, frm_err}, 32'd0);

        $display("[TB] reset mid-frame");
        @(posedge clk);
        #1;
        apply_stimulus(8'h11, 1'b1, 16);
        apply_stimulus(8'h22, 1'b1, 16);
        apply_stimulus(8'h33, 1'b1, 16);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("t5_rdy_queued", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("t5_rst_rdy", {31'd0, rdy}, 32'd0);
        check_output("t5_rst_data", {24'd0, data}, 32'd0);
        check_output("t5_rst_ovr", {31'd0, ovr}, 32'd0);
        check_output("t5_rst_frm", {31'd0, frm_err}, 32'd0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(8'h81);
        apply_stimulus(8'h81, 1'b1, 16);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("t5_rdy_fresh", {31'd0, rdy}, 32'd1);
        pop_n(1);
        @(negedge clk);
        check_output("t5_queue_left", exp_q.size(), 32'd0);

        $display("[TB] full boundary with simultaneous pop");
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'hB0 + 8'(i));
            apply_stimulus(8'hB0 + 8'(i), 1'b1, 16);
        end
        exp_q.push_back(8'hEE);
        fork
            apply_stimulus(8'hEE, 1'b1, 16);
            begin
                repeat (154) @(posedge clk);
                #1 done = 1'b1;
                @(posedge clk);
                #1 done = 1'b0;
            end
        join
        @(negedge clk);
        check_output("t6_ovr", {31'd0, ovr}, 32'd0);
        check_output("t6_head", {24'd0, data}, 32'hB1);
        pop_n(16);
        @(negedge clk);
        check_output("t6_rdy_drained", {31'd0, rdy}, 32'd0);
        check_output("t6_queue_left", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
